// File: rtl/tag_pkg.sv
// Shared defaults and tag type for the reorder-buffer tag free list.
package tag_pkg;
    localparam int TAG_W_DEF    = 5;
    localparam int NUM_TAGS_DEF = 32;

    typedef logic [TAG_W_DEF-1:0] tag_t;
endpackage

// File: rtl/tagfifo_ptr.sv
// Modulo-NUM_TAGS pointer with +0/+1/+2 advance and a combinational ptr+1 view.
module tagfifo_ptr
    import tag_pkg::*;
#(
    parameter int TAG_W    = TAG_W_DEF,
    parameter int NUM_TAGS = NUM_TAGS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic [1:0]       i_adv,
    output logic [TAG_W-1:0] o_ptr,
    output logic [TAG_W-1:0] o_ptr_p1
);

    logic [TAG_W-1:0] r_ptr;

    // One extra bit holds ptr+2 before folding back below NUM_TAGS.
    function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] ptr,
                                                  input logic [1:0]       inc);
        logic [TAG_W:0] sum;
        sum = {1'b0, ptr} + {{(TAG_W-1){1'b0}}, inc};
        if (sum >= (TAG_W+1)'(NUM_TAGS))
            sum = sum - (TAG_W+1)'(NUM_TAGS);
        return sum[TAG_W-1:0];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_ptr <= '0;
        else if (i_clear)
            r_ptr <= '0;
        else
            r_ptr <= wrap_add(r_ptr, i_adv);
    end

    assign o_ptr    = r_ptr;
    assign o_ptr_p1 = wrap_add(r_ptr, 2'd1);

endmodule

// File: rtl/tag_freelist.sv
// Dual-port free list of reorder-buffer tags: up to two allocations and two returns per cycle.
module tag_freelist
    import tag_pkg::*;
#(
    parameter int TAG_W     = TAG_W_DEF,
    parameter int NUM_TAGS  = NUM_TAGS_DEF,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [TAG_W-1:0] RB_Tag,
    input  logic             RB_Tag_Valid,
    input  logic [TAG_W-1:0] RB_Tag1,
    input  logic             RB_Tag1_Valid,
    input  logic             Rd_en,
    input  logic             Rd_en1,
    input  logic             Flush,
    output logic [TAG_W-1:0] Tag_Out,
    output logic [TAG_W-1:0] Tag_Out1,
    output logic             tagFifo_full,
    output logic             tagFifo_empty,
    output logic             tagFifo_aempty,
    output logic [TAG_W:0]   tagFifo_count,
    output logic             tagFifo_err
);

    localparam logic [TAG_W+1:0] LP_N = (TAG_W+2)'(NUM_TAGS);

    logic [TAG_W-1:0] r_mem [NUM_TAGS];
    logic [TAG_W:0]   r_count;
    logic             r_err;

    logic [TAG_W-1:0] w_rd_ptr, w_rd_ptr1, w_wr_ptr, w_wr_ptr1, w_wr_addr1;
    logic [1:0]       w_pop_req, w_pop_grant, w_push_req, w_push_acc;
    logic [1:0]       w_rd_adv, w_wr_adv;
    logic             w_proto_err, w_pop_ok, w_push_ok, w_err_set;
    logic [TAG_W+1:0] w_space;
    logic [TAG_W:0]   w_count_nxt;

    assign w_proto_err = Rd_en1 & ~Rd_en;
    assign w_pop_req   = {1'b0, Rd_en} + {1'b0, Rd_en & Rd_en1};
    assign w_pop_ok    = {1'b0, r_count} >= {{TAG_W{1'b0}}, w_pop_req};
    assign w_pop_grant = w_pop_ok ? w_pop_req : 2'd0;

    // Pops granted this cycle free space for this cycle's pushes.
    assign w_push_req  = {1'b0, RB_Tag_Valid} + {1'b0, RB_Tag1_Valid};
    assign w_space     = {1'b0, r_count} - {{TAG_W{1'b0}}, w_pop_grant}
                       + {{TAG_W{1'b0}}, w_push_req};
    assign w_push_ok   = w_space <= LP_N;
    assign w_push_acc  = w_push_ok ? w_push_req : 2'd0;

    assign w_err_set   = w_proto_err | ~w_pop_ok | ~w_push_ok;
    assign w_count_nxt = r_count - {{(TAG_W-1){1'b0}}, w_pop_grant}
                       + {{(TAG_W-1){1'b0}}, w_push_acc};

    assign w_rd_adv    = Flush ? 2'd0 : w_pop_grant;
    assign w_wr_adv    = Flush ? 2'd0 : w_push_acc;
    assign w_wr_addr1  = RB_Tag_Valid ? w_wr_ptr1 : w_wr_ptr;

    tagfifo_ptr #(.TAG_W(TAG_W), .NUM_TAGS(NUM_TAGS)) u_rd_ptr (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (Flush),
        .i_adv    (w_rd_adv),
        .o_ptr    (w_rd_ptr),
        .o_ptr_p1 (w_rd_ptr1)
    );

    tagfifo_ptr #(.TAG_W(TAG_W), .NUM_TAGS(NUM_TAGS)) u_wr_ptr (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (Flush),
        .i_adv    (w_wr_adv),
        .o_ptr    (w_wr_ptr),
        .o_ptr_p1 (w_wr_ptr1)
    );

    // Flip-flop storage so reset and Flush both restore the identity list in one edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAGS; i++)
                r_mem[i] <= TAG_W'(i);
        end else if (Flush) begin
            for (int i = 0; i < NUM_TAGS; i++)
                r_mem[i] <= TAG_W'(i);
        end else if (w_push_ok) begin
            if (RB_Tag_Valid)
                r_mem[w_wr_ptr] <= RB_Tag;
            if (RB_Tag1_Valid)
                r_mem[w_wr_addr1] <= RB_Tag1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= (TAG_W+1)'(NUM_TAGS);
            r_err   <= 1'b0;
        end else if (Flush) begin
            r_count <= (TAG_W+1)'(NUM_TAGS);
        end else begin
            r_count <= w_count_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

    assign Tag_Out        = r_mem[w_rd_ptr];
    assign Tag_Out1       = r_mem[w_rd_ptr1];
    assign tagFifo_count  = r_count;
    assign tagFifo_full   = r_count == (TAG_W+1)'(NUM_TAGS);
    assign tagFifo_empty  = r_count == '0;
    assign tagFifo_aempty = r_count <= (TAG_W+1)'(AEMPTY_TH);
    assign tagFifo_err    = r_err;

endmodule
